icdf_lut_arbiter: RTL and testbench
===================================

# icdf_lut_arbiter

Round-robin arbiter and response scheduler that shares one registered ICDF lookup unit between NUM_REQ Sobol dimension generators. Each generator offers a 32-bit uniform CDF sample over a valid/ready handshake. The arbiter issues at most one lookup per cycle to the LUT and tracks the one-cycle LUT latency. It returns each 16-bit half-precision ICDF result, tagged with the requester ID, through a small backpressured output FIFO. It sits between the Sobol generator array and the Gaussian sample consumer.

## Interface
- NUM_REQ, 4, number of requesters; must be ≥2.
- ID_W, $clog2(NUM_REQ), width of the requester tag.
- FIFO_DEPTH, 2, response FIFO entries; must be a power of 2 and ≥2.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_cdf  in  32*NUM_REQ  per-requester CDF; requester i uses bits [32*i+31:32*i].
- req_ready  out  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i].
- lut_cdf  out  32  CDF driven to the shared LUT; combinational from the granted requester, 0 when there is no grant.
- lut_icdf  in  16  registered LUT output; valid exactly one cycle after the issue cycle.
- rsp_valid  out  1  FIFO non-empty.
- rsp_id  out  ID_W  requester index of the head entry.
- rsp_icdf  out  16  ICDF value of the head entry.
- rsp_ready  in  1  consumer accepts the head when rsp_valid & rsp_ready.

## Operation
- **Issue condition:** issue_en = (fifo_count + infl_vld − pop) < FIFO_DEPTH, where pop = rsp_valid & rsp_ready. Same-cycle pop credit gives full throughput.
- **Round-robin arbitration:** rr_ptr (ID_W bits) starts the search. The first i in order rr_ptr, rr_ptr+1, … (mod NUM_REQ) with req_valid[i] is granted, only if issue_en. req_ready = onehot(grant) else all zeros.
  - On a grant, rr_ptr ← (grant+1) mod NUM_REQ. With no grant, rr_ptr holds.
  - Wrap-around: grant NUM_REQ−1 sets rr_ptr to 0.
- **Issue:** in the grant cycle, lut_cdf equals the granted req_cdf. At the next edge, infl_vld ← 1 and infl_id ← grant; otherwise infl_vld ← 0.
- **Capture:** when infl_vld is 1, lut_icdf and infl_id are written into the FIFO at the next edge. The issue condition guarantees a free slot, so there is no overflow.
- **FIFO:**
  - Read/write pointers of log2(FIFO_DEPTH)+1 bits; wrap occurs naturally.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - A pop of the last entry while a push is pending is legal.
  - Outputs come straight from the head entry, with no extra register.
- **Idle:** when no req_valid is high, nothing is issued and lut_cdf is 0.
- **Full:** no req_ready is asserted. Pending requests keep rr_ptr ordering, so a stalled requester cannot be skipped repeatedly.
- **Reset mid-operation:** the in-flight lookup and all FIFO contents are discarded without being emitted. The upstream requester does not re-send them.
- The arbiter never alters the data; ICDF values are exactly the LUT output.

## Timing
- **Reset values:** req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_icdf = 0, lut_cdf = 0, rr_ptr = 0, infl_vld = 0, FIFO empty.
- **Latency:** accept at cycle t → LUT output valid at t+1 → rsp_valid at t+2 when the FIFO is empty.
- **Throughput:** 1 result per cycle while rsp_ready = 1.
- **Backpressure:** with rsp_ready held at 0, exactly FIFO_DEPTH requests are accepted, then req_ready stays 0 until a pop.
- req_ready depends combinationally on req_valid, rr_ptr, FIFO state and rsp_ready. Requesters must not make req_valid depend on req_ready.

## Configuration
- **ICDF_ARB_FIXED_PRI_EN:**
  - Defined: fixed priority, lowest index wins, rr_ptr is removed.
  - Undefined (default): round-robin as described above.
  - Handshake, latency and FIFO behaviour are identical in both builds.

## Test plan
- **Single request:** after reset, req_valid[0] = 1 with cdf 0x0000_0000 for one accepted cycle, LUT attached → rsp_valid at t+2 with rsp_id = 0, rsp_icdf = 0xc152.
- **Upper-half mirror:** requester 2 sends cdf 0x8000_0000 → rsp_id = 2, rsp_icdf = 0x2103.
- **Fairness:** all 4 requesters valid continuously with rsp_ready = 1 → grants 0,1,2,3,0,1,… and one rsp per cycle from t+2. Under ICDF_ARB_FIXED_PRI_EN, only requester 0 is granted.
- **Backpressure:** rsp_ready = 0, all requesters valid → exactly 2 accepts, then req_ready = 0. Raising rsp_ready drains the entries in order with ids 0 then 1, and issue resumes at rr_ptr = 2.
- **Simultaneous push/pop:** FIFO holds 1 entry, with pop, capture and issue in the same cycle → fifo_count stays 1 and no data is lost or duplicated.
- **Reset mid-flight:** assert rst_n low one cycle after an accept → rsp_valid = 0 after release and no stale response appears.

Source files
------------

// File: rtl/icdf_lut_arbiter.sv
// rtl/icdf_lut_arbiter.sv - round-robin arbiter sharing one registered ICDF LUT, with tagged response FIFO
// Optional build macro ICDF_ARB_FIXED_PRI_EN selects fixed lowest-index priority instead of round-robin.
module icdf_lut_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ),
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [32*NUM_REQ-1:0]   req_cdf_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic [31:0]             lut_cdf_o,
  input  logic [15:0]             lut_icdf_i,
  output logic                    rsp_valid_o,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [15:0]             rsp_icdf_o,
  input  logic                    rsp_ready_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [ID_W-1:0] gnt_id;
  logic            gnt_found;
  logic            issue_en;
  logic            grant;
  logic            push;
  logic            pop;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   fifo_count;
  logic [PW:0]     occupancy;
  logic            infl_vld_q, infl_vld_d;
  logic [ID_W-1:0] infl_id_q, infl_id_d;
  logic [ID_W-1:0] mem_id_q   [FIFO_DEPTH];
  logic [15:0]     mem_icdf_q [FIFO_DEPTH];

`ifndef ICDF_ARB_FIXED_PRI_EN
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

  assign fifo_count  = wr_ptr_q - rd_ptr_q;
  assign rsp_valid_o = (fifo_count != '0);
  assign rsp_id_o    = mem_id_q[rd_ptr_q[AW-1:0]];
  assign rsp_icdf_o  = mem_icdf_q[rd_ptr_q[AW-1:0]];
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign push        = infl_vld_q;

  // Credit the same-cycle pop so a full FIFO that is draining still issues every cycle.
  assign occupancy = {1'b0, fifo_count} + (PW+1)'(infl_vld_q) - (PW+1)'(pop);
  assign issue_en  = occupancy < (PW+1)'(FIFO_DEPTH);

  always_comb begin : arb
    int idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ICDF_ARB_FIXED_PRI_EN
      idx = k;
`else
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
`endif
      if (!gnt_found && req_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

  assign grant = gnt_found & issue_en;

  always_comb begin
    req_ready_o = '0;
    lut_cdf_o   = '0;
    infl_vld_d  = grant;
    infl_id_d   = infl_id_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (grant) begin
      req_ready_o[gnt_id] = 1'b1;
      lut_cdf_o           = req_cdf_i[int'(gnt_id)*32 +: 32];
      infl_id_d           = gnt_id;
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

`ifndef ICDF_ARB_FIXED_PRI_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      infl_vld_q <= 1'b0;
      infl_id_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_id_q[i]   <= '0;
        mem_icdf_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      infl_vld_q <= infl_vld_d;
      infl_id_q  <= infl_id_d;
      // LUT output belongs to the lookup issued in the previous cycle.
      if (push) begin
        mem_id_q[wr_ptr_q[AW-1:0]]   <= infl_id_q;
        mem_icdf_q[wr_ptr_q[AW-1:0]] <= lut_icdf_i;
      end
    end
  end

endmodule

// File: tb/tb_icdf_lut_arbiter.sv
// tb/tb_icdf_lut_arbiter.sv - randomized self-checking bench for icdf_lut_arbiter against a queue-based model
module tb_icdf_lut_arbiter;

  localparam int N = 4;
  localparam int DEPTH = 2;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [127:0]  req_cdf;
  logic [3:0]    req_ready;
  logic [31:0]   lut_cdf;
  logic [15:0]   lut_icdf;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_icdf;
  logic          rsp_ready;

  int n_vec = 0;
  int n_err = 0;

  int          q_id[$];
  logic [15:0] q_icdf[$];
  bit          m_infl;
  int          m_infl_id;
  logic [15:0] m_infl_icdf;
  int          m_rr;
  logic [3:0]  last_gnt;

  icdf_lut_arbiter #(.NUM_REQ(N), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_cdf_i   (req_cdf),
    .req_ready_o (req_ready),
    .lut_cdf_o   (lut_cdf),
    .lut_icdf_i  (lut_icdf),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_icdf_o  (rsp_icdf),
    .rsp_ready_i (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lut_f(input logic [31:0] c);
    if (c == 32'h0000_0000)      return 16'hc152;
    else if (c == 32'h8000_0000) return 16'h2103;
    else                         return c[31:16] ^ c[15:0] ^ 16'h5a5a;
  endfunction

  always @(posedge clk) lut_icdf <= lut_f(lut_cdf);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q_id.delete();
    q_icdf.delete();
    m_infl = 1'b0;
    m_rr   = 0;
  endtask

  task automatic step(input logic [3:0] v, input logic [127:0] cdf, input logic rr);
    int          g;
    bit          pop;
    bit          room;
    logic [3:0]  exp_rdy;
    logic [31:0] exp_cdf;
    req_valid = v;
    req_cdf   = cdf;
    rsp_ready = rr;
    #2;
    check("rsp_valid", rsp_valid, q_id.size() > 0);
    if (q_id.size() > 0) begin
      check("rsp_id", rsp_id, q_id[0]);
      check("rsp_icdf", rsp_icdf, q_icdf[0]);
    end
    pop  = (q_id.size() > 0) && rr;
    room = (q_id.size() + m_infl - pop) < DEPTH;
    g = -1;
    if (room) begin
      for (int k = 0; k < N; k++) begin
`ifdef ICDF_ARB_FIXED_PRI_EN
        int i = k;
`else
        int i = (m_rr + k) % N;
`endif
        if (g < 0 && v[i]) g = i;
      end
    end
    exp_rdy = '0;
    exp_cdf = '0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      exp_cdf    = cdf[32*g +: 32];
    end
    check("req_ready", req_ready, exp_rdy);
    check("lut_cdf", lut_cdf, exp_cdf);
    last_gnt = req_ready;
    if (pop) begin
      void'(q_id.pop_front());
      void'(q_icdf.pop_front());
    end
    if (m_infl) begin
      q_id.push_back(m_infl_id);
      q_icdf.push_back(m_infl_icdf);
    end
    m_infl = (g >= 0);
    if (g >= 0) begin
      m_infl_id   = g;
      m_infl_icdf = lut_f(exp_cdf);
      m_rr        = (g + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_cdf   = '0;
    rsp_ready = 1'b0;
    model_reset();
    #1;
    check("rst_req_ready", req_ready, 4'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 2'd0);
    check("rst_rsp_icdf", rsp_icdf, 16'h0);
    check("rst_lut_cdf", lut_cdf, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          acc;
    logic [3:0]  exp_g;
    logic [127:0] all_cdf;
    all_cdf = {32'h1111_4444, 32'h2222_3333, 32'h3333_2222, 32'h4444_1111};

    // single request, lower tail
    do_reset();
    step(4'b0001, 128'h0, 1'b1);
    check("single_acc", last_gnt, 4'b0001);
    step(4'b0000, 128'h0, 1'b1);
    check("single_valid", rsp_valid, 1'b1);
    check("single_id", rsp_id, 2'd0);
    check("single_icdf", rsp_icdf, 16'hc152);
    repeat (2) step(4'b0000, 128'h0, 1'b1);

    // upper-half mirror from requester 2
    do_reset();
    step(4'b0100, {32'h0, 32'h8000_0000, 64'h0}, 1'b1);
    step(4'b0000, 128'h0, 1'b1);
    check("mirror_id", rsp_id, 2'd2);
    check("mirror_icdf", rsp_icdf, 16'h2103);
    repeat (2) step(4'b0000, 128'h0, 1'b1);

    // fairness with everyone valid
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, all_cdf, 1'b1);
`ifdef ICDF_ARB_FIXED_PRI_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (k % 4);
`endif
      check("fair_gnt", last_gnt, exp_g);
    end
    repeat (3) step(4'b0000, 128'h0, 1'b1);

    // backpressure: exactly DEPTH accepts, then resume order
    do_reset();
    acc = 0;
    repeat (5) begin
      step(4'b1111, all_cdf, 1'b0);
      acc += $countones(last_gnt);
    end
    check("bp_accepts", acc, DEPTH);
    check("bp_stall", req_ready, 4'b0);
    step(4'b1111, all_cdf, 1'b1);
`ifdef ICDF_ARB_FIXED_PRI_EN
    check("bp_resume", last_gnt, 4'b0001);
`else
    check("bp_resume", last_gnt, 4'b0100);
`endif
    repeat (4) step(4'b0000, 128'h0, 1'b1);

    // simultaneous push, pop and issue with one entry held
    do_reset();
    step(4'b0001, all_cdf, 1'b0);
    step(4'b0010, all_cdf, 1'b0);
    step(4'b0100, all_cdf, 1'b1);
    check("pp_valid", rsp_valid, 1'b1);
    check("pp_head", rsp_id, 2'd1);
    step(4'b0000, 128'h0, 1'b0);
    repeat (4) step(4'b0000, 128'h0, 1'b1);

    // reset one cycle after an accept
    do_reset();
    step(4'b0001, all_cdf, 1'b1);
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    check("rstmid_during", rsp_valid, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_valid", rsp_valid, 1'b0);
    repeat (4) step(4'b0000, 128'h0, 1'b1);

    // randomized traffic
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      logic [127:0] c;
      c = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) c[31:0] = 32'h0;
      if ($urandom_range(0, 7) == 0) c[63:32] = 32'h8000_0000;
      step(4'($urandom_range(0, 15)), c, $urandom_range(0, 9) < 7);
    end
    repeat (4) step(4'b0000, 128'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
